// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit.
//   state_e      - fetch FSM state encoding (FETCH, WAIT, HOLD)
//   MODE_*       - redirect_mode encodings (3 is reserved and ignored)
package fetch_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,   // request issued to instruction memory
      WAIT  = 2'd1,   // one request outstanding, waiting for the response
      HOLD  = 2'd2    // instruction presented downstream until consumed
   } state_e;

   localparam logic [1:0] MODE_BRANCH = 2'd0;
   localparam logic [1:0] MODE_JUMP   = 2'd1;
   localparam logic [1:0] MODE_JR     = 2'd2;

endpackage

// File: rtl/fetch_target_gen.sv
// fetch_target_gen: combinational redirect target computation.
//   redirect_valid/mode  - redirect request and its kind
//   redirect_base        - PC+STEP of the redirecting instruction
//   redirect_imm         - branch word offset or 26-bit jump index
//   redirect_reg         - jump-register target
//   target_valid         - redirect is real (reserved mode suppressed)
//   target               - next fetch PC
module fetch_target_gen
   import fetch_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             redirect_valid,
   input  logic [1:0]       redirect_mode,
   input  logic [WIDTH-1:0] redirect_base,
   input  logic [WIDTH-1:0] redirect_imm,
   input  logic [WIDTH-1:0] redirect_reg,
   output logic             target_valid,
   output logic [WIDTH-1:0] target
);

   // Clearing the low two bits by mask keeps every register bit in use.
   localparam logic [WIDTH-1:0] WORD_MASK = ~WIDTH'(3);

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      target_valid = 1'b0;
      target       = '0;
      case (redirect_mode)
         MODE_BRANCH: begin
            target_valid = redirect_valid;
            target       = redirect_base + (redirect_imm << 2);
         end
         MODE_JUMP: begin
            target_valid = redirect_valid;
            target       = {redirect_base[WIDTH-1:28], redirect_imm[25:0], 2'b00};
         end
         MODE_JR: begin
            target_valid = redirect_valid;
            target       = redirect_reg & WORD_MASK;
         end
         default: ;  // reserved mode: no redirect at all
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with redirect support.
//   clk, rst              - rising-edge clock, synchronous active-high reset
//   redirect_*            - one-cycle redirect request (see fetch_target_gen)
//   imem_req_valid/ready  - instruction memory request handshake
//   imem_req_addr         - request address (current pc)
//   imem_rsp_valid/data   - instruction memory response
//   inst_valid/ready      - downstream handshake
//   inst_data/pc/pc4      - fetched word, its address, address + STEP
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter int unsigned      STEP         = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             redirect_valid,
   input  logic [1:0]       redirect_mode,
   input  logic [WIDTH-1:0] redirect_base,
   input  logic [WIDTH-1:0] redirect_imm,
   input  logic [WIDTH-1:0] redirect_reg,
   output logic             imem_req_valid,
   output logic [WIDTH-1:0] imem_req_addr,
   input  logic             imem_req_ready,
   input  logic             imem_rsp_valid,
   input  logic [WIDTH-1:0] imem_rsp_data,
   output logic             inst_valid,
   output logic [WIDTH-1:0] inst_data,
   output logic [WIDTH-1:0] inst_pc,
   output logic [WIDTH-1:0] inst_pc4,
   input  logic             inst_ready
);

   localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] req_pc_q, req_pc_d;
   logic             drop_q, drop_d;
   logic             inst_valid_q, inst_valid_d;
   logic [WIDTH-1:0] inst_data_q, inst_data_d;
   logic [WIDTH-1:0] inst_pc_q, inst_pc_d;
   logic [WIDTH-1:0] inst_pc4_q, inst_pc4_d;

   logic             redir;
   logic [WIDTH-1:0] redir_target;

   fetch_target_gen #(.WIDTH(WIDTH)) u_target_gen (
      .redirect_valid (redirect_valid),
      .redirect_mode  (redirect_mode),
      .redirect_base  (redirect_base),
      .redirect_imm   (redirect_imm),
      .redirect_reg   (redirect_reg),
      .target_valid   (redir),
      .target         (redir_target)
   );

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      req_pc_d       = req_pc_q;
      drop_d         = drop_q;
      inst_valid_d   = inst_valid_q;
      inst_data_d    = inst_data_q;
      inst_pc_d      = inst_pc_q;
      inst_pc4_d     = inst_pc4_q;
      imem_req_valid = 1'b0;

      case (state_q)
         FETCH: begin
            // Request is masked during reset so nothing leaks out before the
            // registers have taken their reset values.
            imem_req_valid = !rst;
            if (imem_req_ready) begin
               pc_d     = pc_q + STEP_W;
               req_pc_d = pc_q;
               state_d  = WAIT;
               // Accepted request now fetches from the wrong path.
               if (redir) drop_d = 1'b1;
            end
         end
         WAIT: begin
            if (imem_rsp_valid) begin
               if (drop_q || redir) begin
                  drop_d  = 1'b0;
                  state_d = FETCH;
               end else begin
                  inst_valid_d = 1'b1;
                  inst_data_d  = imem_rsp_data;
                  inst_pc_d    = req_pc_q;
                  inst_pc4_d   = req_pc_q + STEP_W;
                  state_d      = HOLD;
               end
            end else if (redir) begin
               drop_d = 1'b1;
            end
         end
         HOLD: begin
            if (inst_ready || redir) begin
               inst_valid_d = 1'b0;
               state_d      = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase

      // Redirect overrides the sequential increment in every state.
      if (redir) pc_d = redir_target;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples the values from before this edge.
         state_q      <= FETCH;
         pc_q         <= RESET_VECTOR;
         req_pc_q     <= '0;
         drop_q       <= 1'b0;
         inst_valid_q <= 1'b0;
         inst_data_q  <= '0;
         inst_pc_q    <= '0;
         inst_pc4_q   <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_pc_q     <= req_pc_d;
         drop_q       <= drop_d;
         inst_valid_q <= inst_valid_d;
         inst_data_q  <= inst_data_d;
         inst_pc_q    <= inst_pc_d;
         inst_pc4_q   <= inst_pc4_d;
      end
   end

   assign imem_req_addr = pc_q;
   assign inst_valid    = inst_valid_q;
   assign inst_data     = inst_data_q;
   assign inst_pc       = inst_pc_q;
   assign inst_pc4      = inst_pc4_q;

endmodule
